// File: rtl/logic_gate_pkg.sv
// Shared opcode definitions for the logic gate unit and its gate cell.
package logic_gate_pkg;

    // Opcode that selects which gate result drives f_o.
    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND  = 3'd0;
    localparam opcode_t OP_OR   = 3'd1;
    localparam opcode_t OP_NOT  = 3'd2;
    localparam opcode_t OP_NAND = 3'd3;
    localparam opcode_t OP_NOR  = 3'd4;
    localparam opcode_t OP_XOR  = 3'd5;
    localparam opcode_t OP_XNOR = 3'd6;
    localparam opcode_t OP_BUF  = 3'd7;

    localparam int unsigned NUM_OPS = 8;

endpackage : logic_gate_pkg

// File: rtl/logic_gate_unit_cell.sv
// Purely combinational gate cell: the six fixed gate results plus the
// opcode-selected result. Every output bit depends only on the same bit
// of a_i and b_i.
module gate_cell
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  opcode_t          sel_i,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] not_o,
    output logic [WIDTH-1:0] nand_o,
    output logic [WIDTH-1:0] nor_o,
    output logic [WIDTH-1:0] xor_o,
    output logic [WIDTH-1:0] f_o
);

    // Fixed gate bank; b_i plays no part in NOT.
    always_comb begin
        and_o  = a_i & b_i;
        or_o   = a_i | b_i;
        not_o  = ~a_i;
        nand_o = ~(a_i & b_i);
        nor_o  = ~(a_i | b_i);
        xor_o  = a_i ^ b_i;
    end

    // Opcode mux; the 3-bit opcode space is fully decoded, the default only
    // keeps the block free of latches.
    always_comb begin
        f_o = '0;
        unique case (sel_i)
            OP_AND:  f_o = a_i & b_i;
            OP_OR:   f_o = a_i | b_i;
            OP_NOT:  f_o = ~a_i;
            OP_NAND: f_o = ~(a_i & b_i);
            OP_NOR:  f_o = ~(a_i | b_i);
            OP_XOR:  f_o = a_i ^ b_i;
            OP_XNOR: f_o = ~(a_i ^ b_i);
            OP_BUF:  f_o = a_i;
            default: f_o = '0;
        endcase
    end

endmodule : gate_cell

// File: rtl/logic_gate_unit.sv
// Registered logic gate unit: a gate cell followed by one valid-qualified
// register stage.
//
// Handshake: valid_i is a pure strobe with no backpressure. When valid_i=1
// at a rising edge, a_i/b_i/sel_i are consumed and every result register is
// updated; valid_o is high for exactly the following cycle. When valid_i=0
// the result registers hold and valid_o=0, so operand values (even unknown
// ones) are ignored. Reset zeroes every output (including not_o, nand_o and
// nor_o) and has priority over valid_i.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] not_o,
    output logic [WIDTH-1:0] nand_o,
    output logic [WIDTH-1:0] nor_o,
    output logic [WIDTH-1:0] xor_o,
    output logic [WIDTH-1:0] f_o
);

    logic [WIDTH-1:0] and_d,  and_q;
    logic [WIDTH-1:0] or_d,   or_q;
    logic [WIDTH-1:0] not_d,  not_q;
    logic [WIDTH-1:0] nand_d, nand_q;
    logic [WIDTH-1:0] nor_d,  nor_q;
    logic [WIDTH-1:0] xor_d,  xor_q;
    logic [WIDTH-1:0] f_d,    f_q;
    logic             valid_q;

    gate_cell #(
        .WIDTH (WIDTH)
    ) u_gate_cell (
        .a_i    (a_i),
        .b_i    (b_i),
        .sel_i  (opcode_t'(sel_i)),
        .and_o  (and_d),
        .or_o   (or_d),
        .not_o  (not_d),
        .nand_o (nand_d),
        .nor_o  (nor_d),
        .xor_o  (xor_d),
        .f_o    (f_d)
    );

    // Valid strobe: one-cycle pulse per accepted sample, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    // Result registers: cleared by reset, loaded on valid_i, otherwise held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            and_q  <= '0;
            or_q   <= '0;
            not_q  <= '0;
            nand_q <= '0;
            nor_q  <= '0;
            xor_q  <= '0;
            f_q    <= '0;
        end else if (valid_i) begin
            and_q  <= and_d;
            or_q   <= or_d;
            not_q  <= not_d;
            nand_q <= nand_d;
            nor_q  <= nor_d;
            xor_q  <= xor_d;
            f_q    <= f_d;
        end
    end

    assign valid_o = valid_q;
    assign and_o   = and_q;
    assign or_o    = or_q;
    assign not_o   = not_q;
    assign nand_o  = nand_q;
    assign nor_o   = nor_q;
    assign xor_o   = xor_q;
    assign f_o     = f_q;

endmodule : logic_gate_unit

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit at WIDTH=8. Each 1-bit case from the test plan
// is carried on individual bit lanes of the 8-bit operands.
module tb_logic_gate_unit;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] and_v;
        logic [W-1:0] or_v;
        logic [W-1:0] not_v;
        logic [W-1:0] nand_v;
        logic [W-1:0] nor_v;
        logic [W-1:0] xor_v;
        logic [W-1:0] f_v;
    } exp_t;

    localparam int unsigned REC_W = $bits(exp_t);

    // clock / reset / dut
    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [2:0]   sel_i = '0;
    logic         valid_o;
    logic [W-1:0] and_o, or_o, not_o, nand_o, nor_o, xor_o, f_o;

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .sel_i   (sel_i),
        .valid_o (valid_o),
        .and_o   (and_o),
        .or_o    (or_o),
        .not_o   (not_o),
        .nand_o  (nand_o),
        .nor_o   (nor_o),
        .xor_o   (xor_o),
        .f_o     (f_o)
    );

    // scoreboard
    logic [REC_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_checks = 0;
    int               n_fail = 0;
    exp_t             last_exp = '0;

    // Monitor: one expected record per clock edge, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  act;
            string nm;
            e  = exp_t'(exp_q.pop_front());
            nm = name_q.pop_front();
            act = '{vld: valid_o, and_v: and_o, or_v: or_o, not_v: not_o,
                    nand_v: nand_o, nor_v: nor_o, xor_v: xor_o, f_v: f_o};
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got vld=%b and=%h or=%h not=%h nand=%h nor=%h xor=%h f=%h, expected vld=%b and=%h or=%h not=%h nand=%h nor=%h xor=%h f=%h",
                         nm, act.vld, act.and_v, act.or_v, act.not_v, act.nand_v, act.nor_v, act.xor_v, act.f_v,
                         e.vld, e.and_v, e.or_v, e.not_v, e.nand_v, e.nor_v, e.xor_v, e.f_v);
            end
        end
    end

    // driver: apply inputs for one edge, then queue what that edge must produce
    task automatic drive(input string nm, input logic rst, input logic v,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel, input exp_t e);
        rst_i   = rst;
        valid_i = v;
        a_i     = a;
        b_i     = b;
        sel_i   = sel;
        @(posedge clk);
        #1;
        exp_q.push_back(REC_W'(e));
        name_q.push_back(nm);
        last_exp = e;
    endtask

    // valid sample with hand-computed results
    task automatic send(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel,
                        input logic [W-1:0] e_and, input logic [W-1:0] e_or,
                        input logic [W-1:0] e_not, input logic [W-1:0] e_nand,
                        input logic [W-1:0] e_nor, input logic [W-1:0] e_xor,
                        input logic [W-1:0] e_f);
        exp_t e;
        e = '{vld: 1'b1, and_v: e_and, or_v: e_or, not_v: e_not, nand_v: e_nand,
              nor_v: e_nor, xor_v: e_xor, f_v: e_f};
        drive(nm, 1'b0, 1'b1, a, b, sel, e);
    endtask

    // idle cycle with random operands: results must hold
    task automatic idle(input string nm);
        exp_t e;
        e = last_exp;
        e.vld = 1'b0;
        drive(nm, 1'b0, 1'b0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), e);
    endtask

    // reset cycle with live operands and valid: everything must clear
    task automatic reset_cycle(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(nm, 1'b1, 1'b1, a, b, 3'd2, exp_t'('0));
    endtask

    logic [W-1:0] sweep_f[8];

    initial begin
        sweep_f[0] = 8'hC0; sweep_f[1] = 8'hFC; sweep_f[2] = 8'h0F; sweep_f[3] = 8'h3F;
        sweep_f[4] = 8'h03; sweep_f[5] = 8'h3C; sweep_f[6] = 8'hC3; sweep_f[7] = 8'hF0;

        // reset with all-ones operands and valid high
        reset_cycle("reset_0", 8'hFF, 8'hFF);
        reset_cycle("reset_1", 8'hFF, 8'hFF);
        idle("post_reset_idle_0");
        idle("post_reset_idle_1");

        // NOT sweep 0,1,0,0 with b=0, f selects NOT
        send("not_sweep_0", 8'h00, 8'h00, 3'd2, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        send("not_sweep_1", 8'hFF, 8'h00, 3'd2, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
        send("not_sweep_2", 8'h00, 8'h00, 3'd2, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        send("not_sweep_3", 8'h00, 8'h00, 3'd2, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF);

        // truth table on lanes: bit0 (0,0) bit1 (0,1) bit2 (1,0) bit3 (1,1)
        send("truth_table_and", 8'h0C, 8'h0A, 3'd0, 8'h08, 8'h0E, 8'hF3, 8'hF7, 8'hF1, 8'h06, 8'h08);
        send("truth_table_xnor", 8'h0C, 8'h0A, 3'd6, 8'h08, 8'h0E, 8'hF3, 8'hF7, 8'hF1, 8'h06, 8'hF9);

        // opcode sweep, back to back
        for (int s = 0; s < 8; s++) begin
            send($sformatf("opcode_sweep_sel%0d", s), 8'hF0, 8'hCC, 3'(s),
                 8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, sweep_f[s]);
        end

        // hold for 5 cycles with random operands
        for (int i = 0; i < 5; i++) idle($sformatf("hold_%0d", i));

        // reset mid-stream with valid kept high
        send("stream_pre_reset", 8'hA5, 8'h0F, 3'd5, 8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'hAA);
        reset_cycle("stream_reset", 8'h3C, 8'h55);
        send("stream_post_reset_0", 8'hF0, 8'hCC, 3'd4, 8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'h03);
        send("stream_post_reset_1", 8'h81, 8'h18, 3'd7, 8'h00, 8'h99, 8'h7E, 8'hFF, 8'h66, 8'h99, 8'h81);
        idle("stream_tail_hold");

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_logic_gate_unit
